// File: rtl/rate_counter_pkg.sv
// Shared types, constants and the divider period helper for rate_counter.
package rate_counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned COUNT_W = 2 * DIGIT_W;
  localparam int unsigned BCD_MAX = 9;

  typedef enum logic [1:0] {
    SPEED_FULL = 2'b00,
    SPEED_1X   = 2'b01,
    SPEED_2X   = 2'b10,
    SPEED_4X   = 2'b11
  } speed_t;

  // Two-digit count payload, high digit in the upper nibble.
  typedef struct packed {
    logic [DIGIT_W-1:0] hi;
    logic [DIGIT_W-1:0] lo;
  } count_t;

  // Clock cycles between ticks for a given speed select.
  function automatic int unsigned period(input logic [1:0] speed,
                                         input int unsigned tick_base);
    int unsigned p;
    case (speed_t'(speed))
      SPEED_FULL: p = 1;
      SPEED_1X:   p = tick_base;
      SPEED_2X:   p = 2 * tick_base;
      default:    p = 4 * tick_base;
    endcase
    return p;
  endfunction

  // Limit a loaded nibble to a legal decimal digit.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(BCD_MAX)) ? DIGIT_W'(BCD_MAX) : d;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Tick-rate divider: counts enabled cycles down and strobes advance_c when
// the period expires. A reload restarts the period and suppresses the strobe.
module rate_divider
  import rate_counter_pkg::*;
#(
  parameter int unsigned TICK_BASE = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       reload,
  input  logic [1:0] speed,
  output logic       advance_c
);

  localparam int unsigned DIV_W = $clog2(4 * TICK_BASE);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] reload_val;

  // Speed is only looked at here, so a change lands at the next reload.
  assign reload_val = DIV_W'(period(speed, TICK_BASE) - 1);

  // Due tick: enabled, expired, and not overridden by a load.
  assign advance_c = enable && !reload && (div == '0);

  // Divider down-counter; holds while disabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div <= '0;
    end else if (reload) begin
      div <= reload_val;
    end else if (enable) begin
      if (div == '0) begin
        div <= reload_val;
      end else begin
        div <= div - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/rate_counter.sv
// Two-digit rate-divided display counter feeding two hex_decoder instances.
// Define RATE_COUNTER_BCD_EN for decimal (00-99) counting; default is 8-bit hex.
module rate_counter
  import rate_counter_pkg::*;
#(
  parameter int unsigned TICK_BASE = 50_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [1:0]          speed,
  input  logic                up,
  input  logic                load,
  input  logic [COUNT_W-1:0]  load_value,
  output logic [DIGIT_W-1:0]  digit_lo,
  output logic [DIGIT_W-1:0]  digit_hi,
  output logic                tick,
  output logic                wrap
);

  count_t count;
  count_t step_val;
  count_t load_val;
  logic   step_wrap;
  logic   advance_c;

  rate_divider #(
    .TICK_BASE (TICK_BASE)
  ) u_rate_divider (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .reload    (load),
    .speed     (speed),
    .advance_c (advance_c)
  );

  assign digit_lo = count.lo;
  assign digit_hi = count.hi;

  // Next count for one step in direction up, and whether that step wrapped.
  always_comb begin
    step_val  = count;
    step_wrap = 1'b0;
    load_val  = count_t'(load_value);
`ifdef RATE_COUNTER_BCD_EN
    load_val.hi = bcd_clamp(load_value[COUNT_W-1:DIGIT_W]);
    load_val.lo = bcd_clamp(load_value[DIGIT_W-1:0]);
    if (up) begin
      if (count.lo >= DIGIT_W'(BCD_MAX)) begin
        step_val.lo = '0;
        if (count.hi >= DIGIT_W'(BCD_MAX)) begin
          step_val.hi = '0;
          step_wrap   = 1'b1;
        end else begin
          step_val.hi = count.hi + DIGIT_W'(1);
        end
      end else begin
        step_val.lo = count.lo + DIGIT_W'(1);
      end
    end else begin
      if (count.lo == '0) begin
        step_val.lo = DIGIT_W'(BCD_MAX);
        if (count.hi == '0) begin
          step_val.hi = DIGIT_W'(BCD_MAX);
          step_wrap   = 1'b1;
        end else begin
          step_val.hi = count.hi - DIGIT_W'(1);
        end
      end else begin
        step_val.lo = count.lo - DIGIT_W'(1);
      end
    end
`else
    if (up) begin
      step_val  = count_t'(COUNT_W'(count) + COUNT_W'(1));
      step_wrap = (COUNT_W'(count) == {COUNT_W{1'b1}});
    end else begin
      step_val  = count_t'(COUNT_W'(count) - COUNT_W'(1));
      step_wrap = (COUNT_W'(count) == '0);
    end
`endif
  end

  // Count register with tick/wrap pulses; load beats a due tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= load_val;
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end else if (advance_c) begin
      count <= step_val;
      tick  <= 1'b1;
      wrap  <= step_wrap;
    end else begin
      tick  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rate_counter.sv
// Self-checking bench for rate_counter (TICK_BASE = 4), hex or BCD build.
module tb_rate_counter;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [1:0] speed;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [3:0] digit_lo;
  logic [3:0] digit_hi;
  logic       tick;
  logic       wrap;

  int checks;
  int errors;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       wrap;
  } exp_t;

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       en;
    logic [1:0] spd;
    logic       up;
    exp_t       exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[13];

  rate_counter #(
    .TICK_BASE (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .speed      (speed),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .digit_lo   (digit_lo),
    .digit_hi   (digit_hi),
    .tick       (tick),
    .wrap       (wrap)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Pick the expected count for the build being simulated.
  function automatic logic [7:0] hb(input logic [7:0] hex_v, input logic [7:0] bcd_v);
`ifdef RATE_COUNTER_BCD_EN
    return bcd_v;
`else
    return hex_v;
`endif
  endfunction

  function automatic exp_t mk(input logic [7:0] c, input logic t, input logic w);
    exp_t e;
    e.count = c;
    e.tick  = t;
    e.wrap  = w;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got count=%h tick=%b wrap=%b, expected count=%h tick=%b wrap=%b",
               name, act.count, act.tick, act.wrap, req.count, req.tick, req.wrap);
    end
  endtask

  function automatic exp_t observed();
    return mk({digit_hi, digit_lo}, tick, wrap);
  endfunction

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input string name, input logic ld, input logic [7:0] lv,
                      input logic en, input logic [1:0] spd, input logic u,
                      input exp_t e);
    exp_t req;
    @(negedge clock);
    load = ld; load_value = lv; enable = en; speed = spd; up = u;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      req = sb.pop_front();
      check(name, observed(), req);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    load = 1'b0; enable = 1'b0; speed = 2'b00; up = 1'b1; load_value = 8'h00;
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    enable = 1'b0; speed = 2'b00; up = 1'b1; load = 1'b0; load_value = 8'h00;

    vecs[0]  = '{1'b1, 8'h00, 1'b0, 2'b00, 1'b1, mk(8'h00, 1'b0, 1'b0)};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, mk(hb(8'hFF, 8'h99), 1'b1, 1'b1)};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(8'h00, 1'b1, 1'b1)};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(8'h01, 1'b1, 1'b0)};
    vecs[4]  = '{1'b1, 8'h10, 1'b0, 2'b00, 1'b1, mk(8'h10, 1'b0, 1'b0)};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b0, mk(hb(8'h0F, 8'h09), 1'b1, 1'b0)};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(8'h10, 1'b1, 1'b0)};
    vecs[7]  = '{1'b1, 8'hFE, 1'b0, 2'b00, 1'b1, mk(hb(8'hFE, 8'h99), 1'b0, 1'b0)};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(hb(8'hFF, 8'h00), 1'b1, hb(8'h00, 8'h01) == 8'h01)};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(hb(8'h00, 8'h01), 1'b1, hb(8'h01, 8'h00) == 8'h01)};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 2'b00, 1'b1, mk(hb(8'h00, 8'h01), 1'b0, 1'b0)};
    vecs[11] = '{1'b1, 8'h5A, 1'b0, 2'b00, 1'b1, mk(hb(8'h5A, 8'h59), 1'b0, 1'b0)};
    vecs[12] = '{1'b1, 8'h5A, 1'b1, 2'b00, 1'b1, mk(hb(8'h5A, 8'h59), 1'b0, 1'b0)};

    // Reset state
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset_state", observed(), mk(8'h00, 1'b0, 1'b0));
    @(negedge clock);
    reset = 1'b0;

    // Table: full-speed stepping, wraps, borrow/carry, loads
    for (int i = 0; i < 13; i++) begin
      step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].lv, vecs[i].en,
           vecs[i].spd, vecs[i].up, vecs[i].exp);
    end

    // Asynchronous reset while running with tick high
    step("areset_load", 1'b1, 8'h36, 1'b0, 2'b00, 1'b1, mk(8'h36, 1'b0, 1'b0));
    step("areset_run", 1'b0, 8'h00, 1'b1, 2'b00, 1'b1, mk(8'h37, 1'b1, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check("areset_immediate", observed(), mk(8'h00, 1'b0, 1'b0));
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;

    // speed 01: ticks at enabled edges 1, 5, 9
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      step($sformatf("x1_edge%0d", k), 1'b0, 8'h00, 1'b1, 2'b01, 1'b1,
           mk(8'(1 + (k - 1) / 4), ((k - 1) % 4) == 0, 1'b0));
    end

    // speed 10 with a 5-cycle enable gap: tick on the 9th enabled edge
    do_reset();
    begin
      int n;
      n = 0;
      for (int k = 0; k < 3; k++) begin
        n++;
        step($sformatf("x2_pre%0d", n), 1'b0, 8'h00, 1'b1, 2'b10, 1'b1,
             mk(8'h01, n == 1, 1'b0));
      end
      for (int k = 0; k < 5; k++) begin
        step($sformatf("x2_hold%0d", k), 1'b0, 8'h00, 1'b0, 2'b10, 1'b1,
             mk(8'h01, 1'b0, 1'b0));
      end
      for (int k = 0; k < 6; k++) begin
        n++;
        step($sformatf("x2_post%0d", n), 1'b0, 8'h00, 1'b1, 2'b10, 1'b1,
             mk(n == 9 ? 8'h02 : 8'h01, n == 9, 1'b0));
      end
    end

    // speed 10: load on the due edge suppresses the tick, period restarts
    do_reset();
    step("ld_first", 1'b0, 8'h00, 1'b1, 2'b10, 1'b1, mk(8'h01, 1'b1, 1'b0));
    for (int k = 2; k <= 8; k++) begin
      step($sformatf("ld_wait%0d", k), 1'b0, 8'h00, 1'b1, 2'b10, 1'b1,
           mk(8'h01, 1'b0, 1'b0));
    end
    step("ld_due", 1'b1, 8'h20, 1'b1, 2'b10, 1'b1, mk(8'h20, 1'b0, 1'b0));
    for (int k = 1; k <= 8; k++) begin
      step($sformatf("ld_after%0d", k), 1'b0, 8'h00, 1'b1, 2'b10, 1'b1,
           mk(k == 8 ? 8'h21 : 8'h20, k == 8, 1'b0));
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rate_counter.md
# rate_counter

Two-digit rate-divided display counter for the lab board's 7-segment path. It divides the 50 MHz board clock down to a selectable tick rate and steps an 8-bit count up or down on each tick. It supports hold and parallel load. The low and high 4-bit digits feed two downstream `hex_decoder` instances directly, one per HEX display.

## Interface
Parameters:
- `TICK_BASE`, default 50_000_000: clock cycles per tick at speed `01`. Set to 4 for simulation.

Ports:
- `clock`  in  1  board clock.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  advance divider and counter when high; hold both when low.
- `speed`  in  2  rate select, sampled at each divider reload:
  - `00`: every enabled cycle.
  - `01`: every `TICK_BASE` cycles.
  - `10`: every 2×`TICK_BASE` cycles.
  - `11`: every 4×`TICK_BASE` cycles.
- `up`  in  1  count direction: 1 increments, 0 decrements.
- `load`  in  1  synchronous parallel load of the count.
- `load_value`  in  8  value taken on `load`: `[3:0]` is the low digit, `[7:4]` the high digit.
- `digit_lo`  out  4  low digit of the count; drives a `hex_decoder` `D` input.
- `digit_hi`  out  4  high digit of the count; drives a `hex_decoder` `D` input.
- `tick`  out  1  one-cycle pulse in the first cycle a new count is visible.
- `wrap`  out  1  one-cycle pulse, coincident with `tick`, when the count wrapped.

## Operation
- State:
  - divider down-counter `div`, width `$clog2(4*TICK_BASE)`;
  - count register `{digit_hi, digit_lo}`;
  - registered `tick` and `wrap`.
- Reset values (asynchronous, immediate): `div`=0, digits=0, `tick`=0, `wrap`=0.
- Priority per clock edge, highest first:
  1. `load`: count←`load_value`; `div`←period(`speed`)−1; `tick`=`wrap`=0. This applies regardless of `enable`.
  2. `enable` high and `div`==0: count steps one in direction `up`; `div`←period(`speed`)−1; `tick`=1; `wrap`=1 if the step wrapped.
  3. `enable` high and `div`≠0: `div` decrements; `tick`=`wrap`=0.
  4. `enable` low: `div` and count hold; `tick`=`wrap`=0.
- period(`speed`) = 1, `TICK_BASE`, 2×`TICK_BASE`, 4×`TICK_BASE` for `speed` = 00, 01, 10, 11.
- A change of `speed` takes effect at the next reload. An in-progress `div` value is not truncated.
- Hex arithmetic is a plain 8-bit step:
  - up: 0xFF→0x00 asserts `wrap`;
  - down: 0x00→0xFF asserts `wrap`.
- Simultaneous `load` and a due tick: the load wins, no tick is emitted, and `div` restarts its period.

## Timing
- The first tick comes on the first enabled edge after reset, because `div` resets to 0. After that, ticks are spaced exactly period(`speed`) enabled cycles apart.
- Count, `tick` and `wrap` update on the same edge, so `tick` is high during the first cycle of the new value.
- `load` latency is one edge. The new digits are visible the cycle after `load` is sampled high.
- Disabled cycles do not count toward the period. When `enable` returns, the divider resumes from its held value.
- `reset` asserted mid-period clears every output asynchronously. There is no reset synchroniser in this block; the board top provides deassertion alignment.

## Configuration
- `RATE_COUNTER_BCD_EN` defined: the digits count decimal, 00–99.
  - Up: `digit_lo` 9→0 carries into `digit_hi`; 99→00 asserts `wrap`.
  - Down: `digit_lo` 0→9 borrows; 00→99 asserts `wrap`.
  - On load, any `load_value` nibble greater than 9 is clamped to 9.
- `RATE_COUNTER_BCD_EN` undefined: 8-bit hex counting as described above. `load_value` is taken unmodified.

## Structure
- Package `rate_counter_pkg` holds:
  - speed encodings `SPEED_FULL`, `SPEED_1X`, `SPEED_2X`, `SPEED_4X`;
  - the `period` function;
  - `DIGIT_W`=4 and `BCD_MAX`=9.
- Sub-module `rate_divider` holds `div`, the reload logic and the `enable` gating. Its outputs are a single-cycle advance strobe to the counter, plus a reload input driven by `load`.
- The top-level `rate_counter` holds the digit registers, the hex/BCD step logic, and the `tick`/`wrap` registers.

## Test plan
- Count 0x37 running, `reset` pulsed between edges → digits 0/0, `tick`=0 immediately, with no clock edge needed.
- `speed`=00, `up`=1, load 0xFE, then enable → 0xFF, then 0x00 on successive edges; `wrap`=1 only in the 0x00 cycle.
- `TICK_BASE`=4, `speed`=01, enable from reset → count 1, 2, 3 at enabled edges 1, 5, 9; `tick` high in exactly those cycles.
- `enable`=0, `load`=1, `load_value`=0x5A → `digit_hi`=5, `digit_lo`=A after one edge; `tick`=0. With `RATE_COUNTER_BCD_EN`, the same stimulus gives 5/9.
- `speed`=00, `up`=0 from 0x00 → 0xFF with `wrap`. With `RATE_COUNTER_BCD_EN`: 00→99 with `wrap`, and 10→09 across the borrow.
- `TICK_BASE`=4, `speed`=10, `enable` dropped for 5 cycles after 3 enabled cycles → next tick after 5 further enabled cycles. A `load` on the due edge suppresses that tick and restarts the 8-cycle period.
